serial_alu: RTL

Slice-serial ALU that executes the 3-bit `alu_control` codes produced by the ALU decoder: ADD, SUB, AND, OR and SLT. It sits beside the datapath of the multi-cycle core variant. It latches operands on a start handshake, processes `SLICE` bits per clock LSB-first with a registered carry, and returns the result with a one-cycle `done` pulse. The goal is a small-area ALU; the trade-off is `WIDTH/SLICE` cycles of latency.

---
 rtl/serial_alu.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/serial_alu.sv
// Slice-serial ALU for ADD/SUB/AND/OR/SLT: SLICE bits per clock, LSB first,
// with a registered carry between slices. Result, zero and err appear with a one-cycle done pulse.
module serial_alu #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2:0]       i_alu_control,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_alu_result,
  output logic             o_zero,
  output logic             o_err
);

  // WIDTH must be a multiple of SLICE with at least two slices.
  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [2:0]           r_op;
  logic [CW-1:0]        r_cnt;
  logic                 r_carry;
  logic [WIDTH-SLICE-1:0] r_sh;
  logic [WIDTH-1:0]     r_result;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_zero;
  logic                 r_err;

  logic                 w_in_legal;
  logic                 w_in_sub;
  logic                 w_sub;
  logic [SLICE-1:0]     w_a_k;
  logic [SLICE-1:0]     w_b_k;
  logic [SLICE-1:0]     w_b_inv;
  logic [SLICE:0]       w_sum;
  logic [SLICE-1:0]     w_s;
  logic [WIDTH-1:0]     w_shift;
  logic                 w_d;
  logic                 w_v;
  logic                 w_lt;
  logic                 w_last;
  logic [WIDTH-1:0]     w_final;

  assign w_in_legal = (i_alu_control == OP_ADD) || (i_alu_control == OP_SUB) ||
                      (i_alu_control == OP_AND) || (i_alu_control == OP_OR)  ||
                      (i_alu_control == OP_SLT);
  assign w_in_sub   = (i_alu_control == OP_SUB) || (i_alu_control == OP_SLT);

  // Operands shift right each slice, so the current slice is always at the LSB end.
  assign w_sub   = (r_op == OP_SUB) || (r_op == OP_SLT);
  assign w_a_k   = r_a[SLICE-1:0];
  assign w_b_k   = r_b[SLICE-1:0];
  assign w_b_inv = w_b_k ^ {SLICE{w_sub}};
  assign w_sum   = {1'b0, w_a_k} + {1'b0, w_b_inv} + {{SLICE{1'b0}}, r_carry};

  always_comb begin
    w_s = w_sum[SLICE-1:0];
    case (r_op)
      OP_AND:  w_s = w_a_k & w_b_k;
      OP_OR:   w_s = w_a_k | w_b_k;
      default: w_s = w_sum[SLICE-1:0];
    endcase
  end

  assign w_shift = {w_s, r_sh};
  assign w_last  = (r_cnt == LAST);

  // On the last slice the operand MSBs sit at the top of the current slice.
  assign w_d  = w_sum[SLICE-1];
  assign w_v  = (w_a_k[SLICE-1] ^ w_b_k[SLICE-1]) & (w_a_k[SLICE-1] ^ w_d);
  assign w_lt = w_d ^ w_v;

  assign w_final = (r_op == OP_SLT) ? {{(WIDTH-1){1'b0}}, w_lt} : w_shift;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_ADD;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_sh     <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_busy <= 1'b1;
            if (w_in_legal) begin
              r_a     <= i_src_a;
              r_b     <= i_src_b;
              r_op    <= i_alu_control;
              r_cnt   <= '0;
              r_carry <= w_in_sub;
              r_state <= S_RUN;
            end else begin
              r_result <= '0;
              r_zero   <= 1'b1;
              r_err    <= 1'b1;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_RUN: begin
          r_a     <= r_a >> SLICE;
          r_b     <= r_b >> SLICE;
          r_carry <= w_sum[SLICE];
          r_sh    <= w_shift[WIDTH-1:SLICE];
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_result <= w_final;
            r_zero   <= (w_final == '0);
            r_err    <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_alu_result = r_result;
  assign o_zero       = r_zero;
  assign o_err        = r_err;

endmodule
